// File: rtl/bp_me_lce_req_stream_arbiter_if.sv
// LCE request merge bus: per-requester header/data streams in, one merged stream out.
// The master modport is the arbiter; the slave modport is the surrounding environment.
interface bp_me_lce_req_stream_arbiter_if #(
  parameter int num_req_p      = 2,
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64
);
  localparam int lg_lp = $clog2(num_req_p);

  logic [num_req_p-1:0][header_width_p-1:0] req_header;
  logic [num_req_p-1:0]                     req_has_data;
  logic [num_req_p-1:0]                     req_header_v;
  logic [num_req_p-1:0]                     req_header_ready_and;
  logic [num_req_p-1:0][data_width_p-1:0]   req_data;
  logic [num_req_p-1:0]                     req_data_v;
  logic [num_req_p-1:0]                     req_data_last;
  logic [num_req_p-1:0]                     req_data_ready_and;

  logic [header_width_p-1:0] header;
  logic                      header_v;
  logic                      header_ready_and;
  logic [data_width_p-1:0]   data;
  logic                      data_v;
  logic                      data_last;
  logic                      data_ready_and;
  logic [lg_lp-1:0]          grant_id;

  modport master (
    input  req_header, req_has_data, req_header_v, req_data, req_data_v, req_data_last,
           header_ready_and, data_ready_and,
    output req_header_ready_and, req_data_ready_and,
           header, header_v, data, data_v, data_last, grant_id
  );

  modport slave (
    output req_header, req_has_data, req_header_v, req_data, req_data_v, req_data_last,
           header_ready_and, data_ready_and,
    input  req_header_ready_and, req_data_ready_and,
           header, header_v, data, data_v, data_last, grant_id
  );
endinterface

// File: rtl/bp_me_lce_req_stream_arbiter.sv
// Round-robin merge of LCE request streams; the grant is held from header handshake
// through the last data beat so messages never interleave on the outbound channel.
module bp_me_lce_req_stream_arbiter_lane (
  input  logic reset,
  input  logic hdr_sel,
  input  logic data_sel,
  input  logic header_ready,
  input  logic data_ready,
  output logic hdr_grant,
  output logic data_grant
);
  assign hdr_grant  = ~reset & hdr_sel  & header_ready;
  assign data_grant = ~reset & data_sel & data_ready;
endmodule

module bp_me_lce_req_stream_arbiter #(
  parameter int num_req_p      = 2,
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64
) (
  input logic clk_i,
  input logic reset_i,
  bp_me_lce_req_stream_arbiter_if.master bus
);
  localparam int lg_lp = $clog2(num_req_p);

  typedef enum logic {e_idle, e_data} state_e;

  state_e               state_r, state_n;
  logic [lg_lp-1:0]     ptr_r, ptr_n, gnt_r, gnt_n, win;
  logic                 found;
  logic [num_req_p-1:0] hdr_sel, data_sel, hdr_grant, data_grant;
  logic                 header_v, data_v;
  int unsigned          idx;

  // First valid header at or after the rotating pointer.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = (int'(ptr_r) + i) % num_req_p;
      if (!found && bus.req_header_v[idx]) begin
        found = 1'b1;
        win   = lg_lp'(idx);
      end
    end
  end

  always_comb begin
    state_n      = state_r;
    ptr_n        = ptr_r;
    gnt_n        = gnt_r;
    header_v     = 1'b0;
    data_v       = 1'b0;
    hdr_sel      = '0;
    data_sel     = '0;
    bus.grant_id = win;
    case (state_r)
      e_idle: begin
        header_v     = found;
        hdr_sel[win] = found;
        if (found && bus.header_ready_and && !reset_i) begin
          ptr_n = (win == lg_lp'(num_req_p-1)) ? '0 : win + 1'b1;
          if (bus.req_has_data[win]) begin
            gnt_n   = win;
            state_n = e_data;
          end
        end
      end
      e_data: begin
        bus.grant_id    = gnt_r;
        data_v          = bus.req_data_v[gnt_r];
        data_sel[gnt_r] = 1'b1;
        if (data_v && bus.data_ready_and && bus.req_data_last[gnt_r])
          state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      ptr_r   <= '0;
      gnt_r   <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      gnt_r   <= gnt_n;
    end
  end

  bp_me_lce_req_stream_arbiter_lane lane [num_req_p-1:0] (
    .reset        (reset_i),
    .hdr_sel      (hdr_sel),
    .data_sel     (data_sel),
    .header_ready (bus.header_ready_and),
    .data_ready   (bus.data_ready_and),
    .hdr_grant    (hdr_grant),
    .data_grant   (data_grant)
  );

  // Valids are forced low during reset so a dropped message cannot leak a beat.
  assign bus.req_header_ready_and = hdr_grant;
  assign bus.req_data_ready_and   = data_grant;
  assign bus.header               = bus.req_header[win];
  assign bus.header_v             = header_v & ~reset_i;
  assign bus.data                 = bus.req_data[gnt_r];
  assign bus.data_last            = bus.req_data_last[gnt_r];
  assign bus.data_v               = data_v & ~reset_i;
endmodule

// File: tb/tb_bp_me_lce_req_stream_arbiter.sv
// Directed bench for the LCE request stream arbiter with three requesters.
module tb_bp_me_lce_req_stream_arbiter;
  localparam int N  = 3;
  localparam int HW = 16;
  localparam int DW = 16;

  logic clk_i, reset_i;
  int checks = 0;
  int errors = 0;
  int b;
  logic rdy;

  bp_me_lce_req_stream_arbiter_if #(.num_req_p(N), .header_width_p(HW), .data_width_p(DW)) bus ();

  bp_me_lce_req_stream_arbiter #(.num_req_p(N), .header_width_p(HW), .data_width_p(DW)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i              = 1'b1;
    bus.req_header       = '0;
    bus.req_has_data     = '0;
    bus.req_header_v     = '0;
    bus.req_data         = '0;
    bus.req_data_v       = '0;
    bus.req_data_last    = '0;
    bus.header_ready_and = 1'b1;
    bus.data_ready_and   = 1'b1;
    for (int k = 0; k < N; k++) bus.req_header[k] = 16'hA000 + 16'(k);

    // Valid/ready outputs stay low while reset is held.
    bus.req_header_v = 3'b111;
    bus.req_data_v   = 3'b111;
    #2;
    chk("rst_header_v", 64'(bus.header_v), 64'd0);
    chk("rst_hdr_ready", 64'(bus.req_header_ready_and), 64'd0);
    chk("rst_data_v", 64'(bus.data_v), 64'd0);
    chk("rst_state", 64'(dut.state_r), 64'd0);
    chk("rst_ptr", 64'(dut.ptr_r), 64'd0);
    bus.req_header_v = '0;
    bus.req_data_v   = '0;
    tick();
    reset_i = 1'b0;

    // Lone requester 1, no data.
    bus.req_header_v = 3'b010;
    #1;
    chk("t1_header_v", 64'(bus.header_v), 64'd1);
    chk("t1_grant", 64'(bus.grant_id), 64'd1);
    chk("t1_header", 64'(bus.header), 64'hA001);
    chk("t1_ready", 64'(bus.req_header_ready_and), 64'b010);
    tick();
    chk("t1_ptr", 64'(dut.ptr_r), 64'd2);
    chk("t1_state", 64'(dut.state_r), 64'd0);

    // Requesters 0 and 1 continuously valid: grants alternate starting from 0.
    bus.req_header_v = 3'b011;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_grant", 64'(bus.grant_id), 64'(i % 2));
      chk("t2_ready", 64'(bus.req_header_ready_and), 64'(1 << (i % 2)));
      tick();
    end
    chk("t2_ptr", 64'(dut.ptr_r), 64'd2);

    // Pointer at 2 with valids on 0 and 2: 2 first, then 0, pointer wraps.
    bus.req_header_v = 3'b101;
    #1;
    chk("t5_grant_a", 64'(bus.grant_id), 64'd2);
    chk("t5_ready_a", 64'(bus.req_header_ready_and), 64'b100);
    tick();
    chk("t5_ptr_a", 64'(dut.ptr_r), 64'd0);
    chk("t5_grant_b", 64'(bus.grant_id), 64'd0);
    tick();
    chk("t5_ptr_b", 64'(dut.ptr_r), 64'd1);
    bus.req_header_v = 3'b100;
    #1;
    chk("t5_grant_c", 64'(bus.grant_id), 64'd2);
    tick();
    chk("t5_ptr_c", 64'(dut.ptr_r), 64'd0);

    // Req0 header + 4 beats with req1 pending; req1 stray data held off.
    bus.req_header_v = 3'b011;
    bus.req_has_data = 3'b001;
    #1;
    chk("t3_grant", 64'(bus.grant_id), 64'd0);
    chk("t3_header", 64'(bus.header), 64'hA000);
    chk("t3_hdr_ready", 64'(bus.req_header_ready_and), 64'b001);
    chk("t3_data_v_hdr", 64'(bus.data_v), 64'd0);
    tick();
    chk("t3_state", 64'(dut.state_r), 64'd1);
    chk("t3_ptr", 64'(dut.ptr_r), 64'd1);
    bus.req_header_v = 3'b010;
    bus.req_data_v   = 3'b011;
    bus.req_data[1]  = 16'hE0E0;
    for (int j = 0; j < 4; j++) begin
      bus.req_data[0]      = 16'hD000 + 16'(j);
      bus.req_data_last[0] = (j == 3);
      #1;
      chk("t3_data", 64'(bus.data), 64'hD000 + 64'(j));
      chk("t3_last", 64'(bus.data_last), 64'(j == 3));
      chk("t3_data_ready", 64'(bus.req_data_ready_and), 64'b001);
      chk("t3_hdr_blocked", 64'(bus.header_v), 64'd0);
      tick();
    end
    chk("t3_back_idle", 64'(dut.state_r), 64'd0);
    bus.req_data_v       = '0;
    bus.req_data_last[0] = 1'b0;
    #1;
    chk("t3_req1_grant", 64'(bus.grant_id), 64'd1);
    chk("t3_req1_ready", 64'(bus.req_header_ready_and), 64'b010);
    tick();
    bus.req_header_v = '0;
    bus.req_has_data = '0;

    // Req2 with 3 beats while downstream ready toggles.
    bus.req_header_v = 3'b100;
    bus.req_has_data = 3'b100;
    #1;
    chk("t4_grant", 64'(bus.grant_id), 64'd2);
    tick();
    bus.req_header_v = '0;
    bus.req_data_v   = 3'b100;
    b = 0;
    for (int c = 0; c < 5; c++) begin
      rdy                  = (c % 2 == 0);
      bus.data_ready_and   = rdy;
      bus.req_data[2]      = 16'hF000 + 16'(b);
      bus.req_data_last[2] = (b == 2);
      #1;
      chk("t4_data", 64'(bus.data), 64'hF000 + 64'(b));
      chk("t4_data_v", 64'(bus.data_v), 64'd1);
      chk("t4_ready", 64'(bus.req_data_ready_and), 64'({rdy, 2'b00}));
      tick();
      if (rdy) b++;
    end
    chk("t4_back_idle", 64'(dut.state_r), 64'd0);
    bus.data_ready_and   = 1'b1;
    bus.req_data_v       = '0;
    bus.req_data_last    = '0;
    bus.req_has_data     = '0;

    // Req1 4-beat message, async reset after beat 2.
    bus.req_header_v = 3'b010;
    bus.req_has_data = 3'b010;
    #1;
    chk("t6_grant", 64'(bus.grant_id), 64'd1);
    tick();
    chk("t6_state", 64'(dut.state_r), 64'd1);
    bus.req_header_v = '0;
    bus.req_has_data = '0;
    bus.req_data_v   = 3'b010;
    for (int j = 0; j < 2; j++) begin
      bus.req_data[1] = 16'hC000 + 16'(j);
      #1;
      chk("t6_data", 64'(bus.data), 64'hC000 + 64'(j));
      tick();
    end
    bus.req_data[1] = 16'hC002;
    #1;
    chk("t6_beat3_v", 64'(bus.data_v), 64'd1);
    bus.req_header_v = 3'b001;
    #1;
    reset_i = 1'b1;
    #1;
    chk("t6_rst_data_v", 64'(bus.data_v), 64'd0);
    chk("t6_rst_data_ready", 64'(bus.req_data_ready_and), 64'd0);
    chk("t6_rst_header_v", 64'(bus.header_v), 64'd0);
    chk("t6_rst_state", 64'(dut.state_r), 64'd0);
    chk("t6_rst_ptr", 64'(dut.ptr_r), 64'd0);
    #1;
    reset_i = 1'b0;
    #1;
    chk("t6_post_header_v", 64'(bus.header_v), 64'd1);
    chk("t6_post_grant", 64'(bus.grant_id), 64'd0);
    chk("t6_post_ready", 64'(bus.req_header_ready_and), 64'b001);
    chk("t6_post_data_v", 64'(bus.data_v), 64'd0);
    tick();
    chk("t6_post_state", 64'(dut.state_r), 64'd0);
    chk("t6_post_ptr", 64'(dut.ptr_r), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
